// File: rtl/hidden_spike_buffer.sv
// Hidden-layer spike buffer: per-channel pending-spike counters that hold
// spike requests until the downstream output neuron acknowledges them.
// Spikes that arrive at a full channel are dropped. Drops are counted
// in a saturating counter and flagged in a sticky overflow bit. Illegal
// acknowledges are flagged in a sticky protocol_err bit.
// Port names and the active-high synchronous reset named resetn match the
// surrounding neuron fabric.
// N_CH is only supported at 8, to match the 8-input downstream output neuron.
module hidden_spike_buffer #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned DEPTH_W = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  spikes_raw,
  input  logic [N_CH-1:0]  acks_in,
  output logic [N_CH-1:0]  spikes_out,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             protocol_err,
  output logic             busy
);

  localparam int unsigned PcntW = $clog2(N_CH + 1);
  localparam logic [DEPTH_W-1:0] PMax = '1;
  localparam logic [N_CH-1:0] AckOne = {{(N_CH - 1){1'b0}}, 1'b1};

  logic [DEPTH_W-1:0] p_q [N_CH];
  logic [DEPTH_W-1:0] p_d [N_CH];
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic               overflow_q, overflow_d;
  logic               protocol_err_q, protocol_err_d;

  logic [N_CH-1:0]    dec;
  logic [N_CH-1:0]    drop;
  logic               multi_ack;
  logic               bad_ack;
  logic [PcntW-1:0]   drop_num;
  logic [CNT_W:0]     cnt_sum;

  // Requests are decoded from registered counters only, so spikes_out has
  // no combinational path from any input.
  always_comb begin
    spikes_out = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      spikes_out[i] = (p_q[i] != '0);
    end
    busy = |spikes_out;
  end

  // Classify the acknowledge vector. With more than one bit set, nothing
  // decrements. Ack bits on idle channels never decrement.
  always_comb begin
    multi_ack = ((acks_in & (acks_in - AckOne)) != '0);
    bad_ack   = multi_ack | (|(acks_in & ~spikes_out));
    dec       = acks_in & spikes_out & {N_CH{~multi_ack}};
  end

  // Per-channel counter update. A spike at a full channel is dropped unless
  // the channel is also being acknowledged in the same cycle.
  always_comb begin
    drop = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      p_d[i] = p_q[i];
      if (spikes_raw[i] && !dec[i]) begin
        if (p_q[i] == PMax) begin
          drop[i] = 1'b1;
        end else begin
          p_d[i] = p_q[i] + DEPTH_W'(1);
        end
      end else if (dec[i] && !spikes_raw[i]) begin
        p_d[i] = p_q[i] - DEPTH_W'(1);
      end
    end
  end

  // Saturating drop counter. All drops in one cycle are counted.
  always_comb begin
    drop_num = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      drop_num = drop_num + PcntW'(drop[i]);
    end
    cnt_sum        = {1'b0, drop_count_q} + (CNT_W + 1)'(drop_num);
    drop_count_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    overflow_d     = overflow_q | (|drop);
    protocol_err_d = protocol_err_q | bad_ack;
  end

  // State registers. Reset clears the counters, so any spikes still pending
  // are discarded and are not counted as drops.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        p_q[i] <= '0;
      end
      drop_count_q   <= '0;
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      p_q            <= p_d;
      drop_count_q   <= drop_count_d;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign drop_count   = drop_count_q;
  assign overflow     = overflow_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_hidden_spike_buffer.sv
// Bench for hidden_spike_buffer: two instances share stimulus (CNT_W=16 and
// CNT_W=4). A behavioural model predicts each cycle's outputs. The
// predictions are queued when stimulus is driven, then popped and compared
// after the clock edge.
module tb_hidden_spike_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  spikes_raw;
  logic [7:0]  acks_in;
  logic [7:0]  so16, so4;
  logic [15:0] dc16;
  logic [3:0]  dc4;
  logic        ovf16, ovf4, perr16, perr4, busy16, busy4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] so;
    logic       busy;
    int         dc16;
    int         dc4;
    logic       ovf;
    logic       perr;
  } exp_t;

  exp_t sb[$];

  // Model state
  int m_p [8];
  int m_dc16, m_dc4;
  bit m_ovf, m_perr;

  always #5 clk = ~clk;

  hidden_spike_buffer u_dut16 (
    .clk          (clk),
    .resetn       (resetn),
    .spikes_raw   (spikes_raw),
    .acks_in      (acks_in),
    .spikes_out   (so16),
    .drop_count   (dc16),
    .overflow     (ovf16),
    .protocol_err (perr16),
    .busy         (busy16)
  );

  hidden_spike_buffer #(.CNT_W(4)) u_dut4 (
    .clk          (clk),
    .resetn       (resetn),
    .spikes_raw   (spikes_raw),
    .acks_in      (acks_in),
    .spikes_out   (so4),
    .drop_count   (dc4),
    .overflow     (ovf4),
    .protocol_err (perr4),
    .busy         (busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_so();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = (m_p[i] > 0);
    return v;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic [7:0] raw, input logic [7:0] ack, input logic rst);
    logic [7:0] so;
    int nack;
    int drops;
    bit d;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_p[i] = 0;
      m_dc16 = 0; m_dc4 = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    so    = model_so();
    nack  = $countones(ack);
    drops = 0;
    if (nack > 1 || (ack & ~so) != 0) m_perr = 1;
    for (int i = 0; i < 8; i++) begin
      d = (nack == 1) && ack[i] && so[i];
      if (raw[i] && !d) begin
        if (m_p[i] == 3) drops++;
        else m_p[i]++;
      end else if (d && !raw[i]) begin
        m_p[i]--;
      end
    end
    m_dc16 = (m_dc16 + drops > 65535) ? 65535 : m_dc16 + drops;
    m_dc4  = (m_dc4 + drops > 15) ? 15 : m_dc4 + drops;
    if (drops > 0) m_ovf = 1;
  endtask

  task automatic step(input logic [7:0] raw, input logic [7:0] ack, input logic rst,
                      input string tag);
    exp_t e;
    spikes_raw = raw;
    acks_in    = ack;
    resetn     = rst;
    model_edge(raw, ack, rst);
    e.tag = tag; e.so = model_so(); e.busy = (model_so() != 0);
    e.dc16 = m_dc16; e.dc4 = m_dc4; e.ovf = m_ovf; e.perr = m_perr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_so16"},   32'(so16),   32'(e.so));
    check({e.tag, "_so4"},    32'(so4),    32'(e.so));
    check({e.tag, "_busy"},   32'(busy16), 32'(e.busy));
    check({e.tag, "_dc16"},   32'(dc16),   32'(e.dc16));
    check({e.tag, "_dc4"},    32'(dc4),    32'(e.dc4));
    check({e.tag, "_ovf"},    32'(ovf16),  32'(e.ovf));
    check({e.tag, "_ovf4"},   32'(ovf4),   32'(e.ovf));
    check({e.tag, "_perr"},   32'(perr16), 32'(e.perr));
    check({e.tag, "_perr4"},  32'(perr4),  32'(e.perr));
  endtask

  initial begin
    logic [7:0] raw, ack, so;
    resetn = 1'b1; spikes_raw = '0; acks_in = '0;
    for (int i = 0; i < 8; i++) m_p[i] = 0;
    m_dc16 = 0; m_dc4 = 0; m_ovf = 0; m_perr = 0;

    // Reset
    step(8'h00, 8'h00, 1'b1, "rst0");
    step(8'h00, 8'h00, 1'b1, "rst1");
    check("rst_so_zero", 32'(so16), 32'h0);

    // Single spike
    step(8'h04, 8'h00, 1'b0, "single_spk");
    check("single_so", 32'(so16), 32'h04);
    step(8'h00, 8'h00, 1'b0, "single_hold");
    step(8'h00, 8'h04, 1'b0, "single_ack");
    check("single_drained", 32'(so16), 32'h00);

    // Saturation on channel 0, then drain
    for (int i = 0; i < 5; i++) step(8'h01, 8'h00, 1'b0, "sat_spk");
    check("sat_drops", 32'(dc16), 32'd2);
    check("sat_ovf", 32'(ovf16), 32'd1);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h01, 1'b0, "sat_drain");
    check("sat_empty", 32'(so16[0]), 32'd0);

    // Simultaneous spike + ack at a full channel
    for (int i = 0; i < 3; i++) step(8'h02, 8'h00, 1'b0, "sim_fill");
    step(8'h02, 8'h02, 1'b0, "sim_both");
    check("sim_nodrop", 32'(dc16), 32'd2);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h02, 1'b0, "sim_drain");
    check("sim_empty3", 32'(so16[1]), 32'd0);

    // Multi-drop and saturation of the 4-bit counter
    step(8'h00, 8'h00, 1'b1, "md_rst");
    for (int i = 0; i < 3; i++) step(8'hFF, 8'h00, 1'b0, "md_fill");
    step(8'hFF, 8'h00, 1'b0, "md_drop8");
    check("md_dc8", 32'(dc16), 32'd8);
    for (int i = 0; i < 3; i++) step(8'hFF, 8'h00, 1'b0, "md_sat");
    check("md_dc4_sat", 32'(dc4), 32'd15);
    check("md_dc16_32", 32'(dc16), 32'd32);

    // Protocol errors
    step(8'h00, 8'h00, 1'b1, "pe_rst");
    step(8'h00, 8'h10, 1'b0, "pe_idle_ack");
    check("pe_idle_flag", 32'(perr16), 32'd1);
    step(8'h00, 8'h00, 1'b1, "pe_rst2");
    step(8'h03, 8'h00, 1'b0, "pe_fill");
    step(8'h00, 8'h03, 1'b0, "pe_multi");
    check("pe_multi_so", 32'(so16), 32'h03);
    check("pe_multi_flag", 32'(perr16), 32'd1);

    // Mid-operation reset with spikes presented
    step(8'h07, 8'h00, 1'b0, "mr_fill");
    for (int i = 0; i < 3; i++) step(8'h01, 8'h00, 1'b0, "mr_ovf");
    step(8'hFF, 8'h00, 1'b1, "mr_rst");
    check("mr_so", 32'(so16), 32'h0);
    check("mr_dc", 32'(dc16), 32'h0);

    // Random traffic with mostly legal acks
    for (int n = 0; n < 60; n++) begin
      raw = 8'($urandom);
      so  = model_so();
      ack = '0;
      if ($urandom_range(0, 9) == 0) begin
        ack = 8'($urandom);
      end else if (so != 0 && $urandom_range(0, 2) != 0) begin
        for (int t = 0; t < 16; t++) begin
          int c;
          c = $urandom_range(0, 7);
          if (so[c]) begin
            ack[c] = 1'b1;
            break;
          end
        end
      end
      step(raw, ack, ($urandom_range(0, 29) == 0), "rnd");
    end

    spikes_raw = '0; acks_in = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hidden_spike_buffer.md
HIDDEN_SPIKE_BUFFER -- requirements
Module: hidden_spike_buffer

Interface
REQ-001 Parameter N_CH, default 8, number of hidden-layer spike channels; the only supported value is 8, to match the downstream 8-input output neuron.
REQ-002 Parameter DEPTH_W, default 2, width of each per-channel pending-spike counter; maximum pending count is 2^DEPTH_W-1 (3 at default).
REQ-003 Parameter CNT_W, default 16, width of the dropped-spike counter.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-005 Port resetn, input, 1 bit: synchronous, active-high reset (asserted when 1, sampled on posedge clk).
REQ-006 Port spikes_raw, input, N_CH bits: per-channel spike pulses from hidden neurons; one spike per high cycle.
REQ-007 Port acks_in, input, N_CH bits: one-hot acknowledge from the downstream output neuron, combinationally derived from spikes_out.
REQ-008 Port spikes_out, output, N_CH bits: per-channel request level, feeds the downstream spikes_in.
REQ-009 Port drop_count, output, CNT_W bits: total spikes discarded due to full channels.
REQ-010 Port overflow, output, 1 bit: sticky flag, set on the first discarded spike.
REQ-011 Port protocol_err, output, 1 bit: sticky flag, set on any illegal acknowledge.
REQ-012 Port busy, output, 1 bit: high when any channel has a pending spike.

Function
REQ-013 Each channel i SHALL hold a DEPTH_W-bit pending counter p[i].
REQ-014 spikes_out[i] SHALL equal (p[i] != 0), decoded from registered state only; there is no combinational path from any input to spikes_out.
REQ-015 busy SHALL equal OR of spikes_out.
REQ-016 Valid ack on channel i: acks_in[i]=1 while spikes_out[i]=1; dec[i] = acks_in[i] & spikes_out[i].
REQ-017 Channel i increment: inc[i] = spikes_raw[i].
REQ-018 Update rule, per cycle:
- inc and no dec: p+1.
- dec and no inc: p-1.
- both: p unchanged.
- neither: p unchanged.
REQ-019 Full channel with inc and no dec (p = max): p SHALL stay at max and the spike is dropped, drop[i]=1.
REQ-020 Full channel with inc and dec in the same cycle: p SHALL stay at max with no drop.
REQ-021 drop_count SHALL add popcount(drop[N_CH-1:0]) each cycle and saturate at 2^CNT_W-1 with no wrap-around; multiple same-cycle drops SHALL all be counted.
REQ-022 overflow SHALL be set on the cycle after any drop[i]=1 and hold until reset.
REQ-023 protocol_err SHALL be set on the cycle after either illegal-ack condition occurs, and hold until reset:
- acks_in has more than one bit set; or
- acks_in[i]=1 with spikes_out[i]=0.
REQ-024 Illegal ack bits SHALL NOT decrement any counter.
REQ-025 When acks_in has more than one bit set, no channel SHALL decrement in that cycle.
REQ-026 Latency: a spike on spikes_raw[i] at edge k SHALL make spikes_out[i] high after edge k (visible in cycle k+1), provided p[i] was 0 and no drop occurred.
REQ-027 A channel with p=n and the ack held continuously SHALL drain in exactly n cycles.
REQ-028 Channels SHALL operate independently; the block does no arbitration, since priority is applied downstream.

Reset
REQ-029 While resetn=1 at a clock edge, the block SHALL clear on that edge:
- all p[i] to 0;
- drop_count to 0;
- overflow and protocol_err to 0.
REQ-030 Consequently, spikes_out=0 and busy=0 from the cycle after reset.
REQ-031 Spikes and acks presented during a reset cycle SHALL be ignored.
REQ-032 Pending spikes present at reset assertion SHALL be discarded without counting as drops.

Verification
REQ-033 Single spike: pulse spikes_raw=8'h04 one cycle, no ack -> spikes_out=8'h04 next cycle and held; ack 8'h04 one cycle -> spikes_out=8'h00, busy=0.
REQ-034 Saturation: pulse spikes_raw[0] for 5 consecutive cycles with no ack -> p[0]=3, drop_count=2, overflow=1; then hold acks_in=8'h01 -> spikes_out[0] high exactly 3 more cycles.
REQ-035 Simultaneous: with p[1]=3, assert spikes_raw[1] and acks_in=8'h02 together -> p[1] stays 3, drop_count unchanged.
REQ-036 Multi-drop and saturation: all 8 channels full, spikes_raw=8'hFF for one cycle -> drop_count increments by 8; with CNT_W forced to 4, repeat until count reaches 15 and stays at 15.
REQ-037 Protocol errors:
- acks_in=8'h10 with spikes_out[4]=0 -> protocol_err=1 next cycle, no counter change;
- acks_in=8'h03 with both channels pending -> protocol_err=1, neither counter changes.
REQ-038 Mid-operation reset: with several channels pending and overflow=1, assert resetn for one cycle while spikes_raw=8'hFF -> all outputs 0 next cycle and no drop is counted.
